// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the pwm colour-wheel sequencer.
package pwm_pkg;

    // Hue segments: first letter holds MAX, second letter ramps up/down.
    typedef enum logic [2:0] {
        SEG_RG_UP = 3'd0,
        SEG_GR_DN = 3'd1,
        SEG_GB_UP = 3'd2,
        SEG_BG_DN = 3'd3,
        SEG_BR_UP = 3'd4,
        SEG_RB_DN = 3'd5
    } hue_seg_t;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_t;

    // Width of a pwm_value for a given pwm period.
    function automatic int unsigned duty_w(input int unsigned interval);
        return $clog2(interval);
    endfunction

    // Always-on duty level (pwm drives high while count <= value).
    function automatic int unsigned max_duty(input int unsigned interval);
        return interval - 1;
    endfunction

    // Channel that ramps in a given segment.
    function automatic chan_t ramp_chan(input hue_seg_t seg);
        case (seg)
            SEG_RG_UP: return CH_G;
            SEG_GR_DN: return CH_R;
            SEG_GB_UP: return CH_B;
            SEG_BG_DN: return CH_G;
            SEG_BR_UP: return CH_R;
            default:   return CH_B;
        endcase
    endfunction

    // Even segments ramp up, odd segments ramp down.
    function automatic logic ramp_is_up(input hue_seg_t seg);
        return ~seg[0];
    endfunction

    // Next segment around the wheel.
    function automatic hue_seg_t next_seg(input hue_seg_t seg);
        return (seg == SEG_RB_DN) ? SEG_RG_UP : hue_seg_t'(3'(seg) + 3'd1);
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Free-running step timer: one-cycle tick on the terminal count while enabled.
module pwm_step_timer #(
    parameter int unsigned STEP_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count;

    // Terminal count is only a tick while the timer is allowed to advance.
    assign tick = enable && (count == TERM);

    // Count 0..STEP_CYCLES-1 while enabled, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERM) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Colour-wheel sequencer: walks R/G/B duties around the hue circle in six ramps.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned STEP_CYCLES  = 20000,
    parameter int unsigned DUTY_STEP    = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            restart,
    output logic [$clog2(PWM_INTERVAL)-1:0] duty_r,
    output logic [$clog2(PWM_INTERVAL)-1:0] duty_g,
    output logic [$clog2(PWM_INTERVAL)-1:0] duty_b,
    output logic [2:0]                      segment,
    output logic                            step_pulse
);

    localparam int unsigned DW  = duty_w(PWM_INTERVAL);
    localparam int unsigned DWX = DW + 1;
    localparam logic [DW-1:0]  MAX_V  = DW'(max_duty(PWM_INTERVAL));
    localparam logic [DW-1:0]  STEP_V = DW'(DUTY_STEP);
    localparam logic [DWX-1:0] STEP_X = DWX'(DUTY_STEP);

    logic           tick;
    hue_seg_t       seg_q, seg_d;
    chan_t          ramp_ch;
    logic           ramp_up;
    logic [DW-1:0]  cur_val, up_val, dn_val, new_val;
    logic [DWX-1:0] up_sum;
    logic           at_end;
    logic [DW-1:0]  r_d, g_d, b_d;

    pwm_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (restart),
        .enable(enable),
        .tick  (tick)
    );

    // Saturating ramp of the channel selected by the current segment.
    always_comb begin
        ramp_ch = ramp_chan(seg_q);
        ramp_up = ramp_is_up(seg_q);
        cur_val = duty_r;
        case (ramp_ch)
            CH_G:    cur_val = duty_g;
            CH_B:    cur_val = duty_b;
            default: cur_val = duty_r;
        endcase
        up_sum  = {1'b0, cur_val} + STEP_X;
        up_val  = (up_sum > {1'b0, MAX_V}) ? MAX_V : up_sum[DW-1:0];
        dn_val  = (cur_val < STEP_V) ? '0 : cur_val - STEP_V;
        new_val = ramp_up ? up_val : dn_val;
        at_end  = ramp_up ? (new_val == MAX_V) : (new_val == '0);
    end

    // Segment state register; restart returns to the first segment.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            seg_q <= SEG_RG_UP;
        end else begin
            seg_q <= seg_d;
        end
    end

    // Advance the segment on the tick that lands the ramp on its endpoint.
    always_comb begin
        seg_d = seg_q;
        if (tick && at_end) begin
            seg_d = next_seg(seg_q);
        end
    end

    // Next duties: only the ramping channel moves, and only on a tick.
    always_comb begin
        r_d = duty_r;
        g_d = duty_g;
        b_d = duty_b;
        if (tick) begin
            case (ramp_ch)
                CH_G:    g_d = new_val;
                CH_B:    b_d = new_val;
                default: r_d = new_val;
            endcase
        end
    end

    // Duty and pulse registers.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            duty_r     <= MAX_V;
            duty_g     <= '0;
            duty_b     <= '0;
            step_pulse <= 1'b0;
        end else begin
            duty_r     <= r_d;
            duty_g     <= g_d;
            duty_b     <= b_d;
            step_pulse <= tick;
        end
    end

    assign segment = seg_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: hue-wheel position model plus directed literal checks.
module tb_pwm_fade_sequencer;

    localparam int MAXD = 19;
    localparam int SC   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic restart = 1'b0;
    logic en = 1'b0;
    logic en19 = 1'b0;
    logic chk_en = 1'b0;

    logic [4:0] r0, g0, b0, r1, g1, b1;
    logic [2:0] s0, s1;
    logic       p0, p1;

    int passed = 0;
    int total = 0;

    // Model state per instance: tick index around the wheel, timer, pulse.
    int m_idx [2];
    int m_tmr [2];
    int m_pls [2];
    int m_len [2];
    int m_stp [2];

    always #5 clk = ~clk;

    pwm_fade_sequencer #(.PWM_INTERVAL(20), .STEP_CYCLES(SC), .DUTY_STEP(5)) dut (
        .clk(clk), .rst(rst), .enable(en), .restart(restart),
        .duty_r(r0), .duty_g(g0), .duty_b(b0), .segment(s0), .step_pulse(p0)
    );

    pwm_fade_sequencer #(.PWM_INTERVAL(20), .STEP_CYCLES(SC), .DUTY_STEP(19)) dut19 (
        .clk(clk), .rst(rst), .enable(en19), .restart(restart),
        .duty_r(r1), .duty_g(g1), .duty_b(b1), .segment(s1), .step_pulse(p1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int ramp(input int p, input int st, input bit up);
        int v;
        v = p * st;
        if (up) return (v > MAXD) ? MAXD : v;
        return (MAXD - v < 0) ? 0 : MAXD - v;
    endfunction

    // Expected outputs from the position on the wheel: segment = idx/len, progress = idx%len.
    task automatic exp_out(input int id, input int st, input int len,
                           output int r, output int g, output int b, output int s);
        int p;
        s = id / len;
        p = id % len;
        r = 0; g = 0; b = 0;
        case (s)
            0: begin r = MAXD; g = ramp(p, st, 1'b1); end
            1: begin g = MAXD; r = ramp(p, st, 1'b0); end
            2: begin g = MAXD; b = ramp(p, st, 1'b1); end
            3: begin b = MAXD; g = ramp(p, st, 1'b0); end
            4: begin b = MAXD; r = ramp(p, st, 1'b1); end
            default: begin r = MAXD; b = ramp(p, st, 1'b0); end
        endcase
    endtask

    initial begin
        m_len[0] = 4; m_stp[0] = 5;
        m_len[1] = 1; m_stp[1] = 19;
        m_idx[0] = 0; m_idx[1] = 0;
        m_tmr[0] = 0; m_tmr[1] = 0;
        m_pls[0] = 0; m_pls[1] = 0;
    end

    // Model update on each clock edge from the inputs driven before it.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || restart) begin
                m_idx[i] <= 0;
                m_tmr[i] <= 0;
                m_pls[i] <= 0;
            end else if ((i == 0) ? en : en19) begin
                m_pls[i] <= (m_tmr[i] == SC - 1) ? 1 : 0;
                if (m_tmr[i] == SC - 1) begin
                    m_tmr[i] <= 0;
                    m_idx[i] <= (m_idx[i] + 1) % (6 * m_len[i]);
                end else begin
                    m_tmr[i] <= m_tmr[i] + 1;
                end
            end else begin
                m_pls[i] <= 0;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int er, eg, eb, es;
        if (chk_en) begin
            exp_out(m_idx[0], m_stp[0], m_len[0], er, eg, eb, es);
            chk("m0_r", int'(r0), er);
            chk("m0_g", int'(g0), eg);
            chk("m0_b", int'(b0), eb);
            chk("m0_seg", int'(s0), es);
            chk("m0_pulse", int'(p0), m_pls[0]);
            exp_out(m_idx[1], m_stp[1], m_len[1], er, eg, eb, es);
            chk("m1_r", int'(r1), er);
            chk("m1_g", int'(g1), eg);
            chk("m1_b", int'(b1), eb);
            chk("m1_seg", int'(s1), es);
            chk("m1_pulse", int'(p1), m_pls[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_rgb(input string nm, input int r, input int g, input int b,
                           input int s, input int p);
        chk({nm, "_r"}, int'(r0), r);
        chk({nm, "_g"}, int'(g0), g);
        chk({nm, "_b"}, int'(b0), b);
        chk({nm, "_seg"}, int'(s0), s);
        chk({nm, "_pulse"}, int'(p0), p);
    endtask

    initial begin
        int gup [4];
        int rdn [4];
        gup[0] = 5;  gup[1] = 10; gup[2] = 15; gup[3] = 19;
        rdn[0] = 14; rdn[1] = 9;  rdn[2] = 4;  rdn[3] = 0;

        // Reset for two clocks.
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk_rgb("reset", 19, 0, 0, 0, 0);

        // Green ramps up, segment advances on the fourth tick.
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(SC);
            chk("g_up", int'(g0), gup[k]);
            chk("g_up_pulse", int'(p0), 1);
        end
        chk("seg_after_g", int'(s0), 1);

        // Red ramps down to zero, then segment 2.
        for (int k = 0; k < 4; k++) begin
            cyc(SC);
            chk("r_dn", int'(r0), rdn[k]);
        end
        chk("seg_after_r", int'(s0), 2);

        // Freeze mid-count: two counts taken, hold ten clocks, two more to tick.
        cyc(2);
        en = 1'b0;
        cyc(10);
        chk_rgb("frozen", 0, 19, 0, 2, 0);
        en = 1'b1;
        cyc(1);
        chk("resume_no_tick", int'(p0), 0);
        cyc(1);
        chk_rgb("resume_tick", 0, 19, 5, 2, 1);

        // Remaining 15 ticks close the wheel.
        cyc(15 * SC);
        chk_rgb("wheel", 19, 0, 0, 0, 1);

        // Restart on the terminal-count cycle discards the tick.
        cyc(3 * SC + 3);
        chk("pre_restart_g", int'(g0), 15);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        chk_rgb("restart", 19, 0, 0, 0, 0);
        cyc(SC);
        chk_rgb("after_restart", 19, 5, 0, 0, 1);

        // Run into segment 3, then reset mid-segment.
        cyc(11 * SC + 2);
        chk_rgb("seg3", 0, 19, 19, 3, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_rgb("rst_seg3", 19, 0, 0, 0, 0);

        // Full-size step: one tick per segment.
        en19 = 1'b1;
        cyc(SC);
        chk("s19_seg1", int'(s1), 1);
        chk("s19_g", int'(g1), 19);
        chk("s19_r", int'(r1), 19);
        cyc(2 * SC);
        chk("s19_seg3", int'(s1), 3);
        chk("s19_b", int'(b1), 19);
        cyc(3 * SC);
        chk("s19_wrap_seg", int'(s1), 0);
        chk("s19_wrap_g", int'(g1), 0);
        chk("s19_wrap_b", int'(b1), 0);

        cyc(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
